// File: rtl/udcnt_sweep_ctrl.sv
// Sweep sequencer for an external up/down counter: seeks to lo, then ping-pongs
// lo->hi->lo for a latched number of sweeps, stepping once per prescaler tick.
module udcnt_sweep_ctrl #(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 1,
  parameter int SW_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [SW_W-1:0]  sweeps,
  input  logic [WIDTH-1:0] q,
  output logic             ud,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       dbg_state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEEK = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [SW_W-1:0]   cnt_q, cnt_d;
  logic [SW_W-1:0]   sw_q, sw_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  target;
  logic [SW_W-1:0]   cnt_inc;
  logic              tick;

  // Handshake: start is a level sampled only in IDLE; stop overrides start and
  // aborts any busy state, killing en in the same cycle it is seen.
  always_comb begin
    state_d = state_q;
    presc_d = '0;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = 1'b0;
    target  = lo_q;
    ud      = 1'b0;
    busy    = 1'b0;
    cnt_inc = cnt_q + SW_W'(1);
    tick    = (presc_q == TICK_LAST);

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (lo < hi) begin
            lo_d    = lo;
            hi_d    = hi;
            sw_d    = sweeps;
            cnt_d   = '0;
            state_d = S_SEEK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SEEK: begin
        busy   = 1'b1;
        target = lo_q;
        ud     = (q < lo_q);
        if (q == lo_q) state_d = S_UP;
      end
      S_UP: begin
        busy   = 1'b1;
        target = hi_q;
        ud     = 1'b1;
        if (q == hi_q) state_d = S_DOWN;
      end
      S_DOWN: begin
        busy   = 1'b1;
        target = lo_q;
        if (q == lo_q) begin
          cnt_d = cnt_inc;
          if ((sw_q != '0) && (cnt_inc == sw_q)) state_d = S_DONE;
          else                                   state_d = S_UP;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (busy) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (stop) state_d = S_IDLE;
    end

    // Never step while sitting on the target, so bounds are never overshot.
    en     = tick & busy & (q != target) & ~stop;
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      sw_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_udcnt_sweep_ctrl.sv
// Directed bench for udcnt_sweep_ctrl: two instances (TICK_DIV=1 and 4), each
// closing the loop through a behavioural up/down counter with enable.
module tb_udcnt_sweep_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_UP   = 3'd2;

  logic       clk, rst_n;
  logic       start1, start4, stop;
  logic [3:0] lo, hi, sweeps;
  logic [3:0] q1, q4;
  logic       ud1, en1, busy1, done1, err1;
  logic       ud4, en4, busy4, done4, err4;
  logic [2:0] st1, st4;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];

  udcnt_sweep_ctrl #(.WIDTH(4), .TICK_DIV(1), .SW_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop), .lo(lo), .hi(hi),
    .sweeps(sweeps), .q(q1), .ud(ud1), .en(en1), .busy(busy1), .done(done1),
    .err(err1), .dbg_state(st1)
  );

  udcnt_sweep_ctrl #(.WIDTH(4), .TICK_DIV(4), .SW_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop), .lo(lo), .hi(hi),
    .sweeps(sweeps), .q(q4), .ud(ud4), .en(en4), .busy(busy4), .done(done4),
    .err(err4), .dbg_state(st4)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural counters driven by each sequencer
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q1 <= 4'd0;
    else if (en1) q1 <= ud1 ? q1 + 4'd1 : q1 - 4'd1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q4 <= 4'd0;
    else if (en4) q4 <= ud4 ? q4 + 4'd1 : q4 - 4'd1;
  end

  // driver tasks
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start1_pulse(input logic [3:0] l, input logic [3:0] h, input logic [3:0] s);
    @(negedge clk);
    lo = l; hi = h; sweeps = s; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  // Samples dut1 each negedge; stops two cycles after the first done pulse.
  task automatic collect1(input int max_cyc, output int n_en, output int n_done,
                          output int n_wrap, output int n_top, output bit tmo);
    logic [3:0] prev;
    int post;
    obs_q.delete();
    prev = q1; n_en = 0; n_done = 0; n_wrap = 0; n_top = 0; post = -1; tmo = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      if (q1 !== prev) begin
        obs_q.push_back(q1);
        if ((prev == 4'd15 && q1 == 4'd0) || (prev == 4'd0 && q1 == 4'd15)) n_wrap++;
        if (q1 == 4'd15) n_top++;
        prev = q1;
      end
      if (en1) n_en++;
      if (done1) begin
        n_done++;
        if (post < 0) post = 2;
      end
      if (post == 0) begin
        tmo = 1'b0;
        break;
      end
      if (post > 0) post--;
      @(negedge clk);
    end
  endtask

  task automatic wait_up_at(input logic [3:0] val, output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (q1 == val && st1 == ST_UP) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // tests
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({en1, ud1, busy1, done1, err1, en4, ud4, busy4, done4, err4} !== 10'b0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%b expected all zero",
               {en1, ud1, busy1, done1, err1, en4, ud4, busy4, done4, err4});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({en1, ud1, busy1, done1, err1, st1, st4} !== 11'b0) begin
      errors++;
      $display("FAIL reset_release: outputs/state=%b expected all zero",
               {en1, ud1, busy1, done1, err1, st1, st4});
    end
  endtask

  task automatic test_sweep_basic();
    int n_en, n_done, n_wrap, n_top;
    bit tmo;
    pulse_reset();
    start1_pulse(4'd2, 4'd5, 4'd1);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_after_start: got %b expected 1", busy1);
    end
    lo = 4'd9; hi = 4'd3; sweeps = 4'd7;
    collect1(60, n_en, n_done, n_wrap, n_top, tmo);
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2};
    checks++;
    if (tmo) begin
      errors++;
      $display("FAIL basic_timeout: no done within budget");
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_q_len: got %0d steps expected %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL basic_q[%0d]: got %0d expected %0d", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (n_en != 8) begin
      errors++;
      $display("FAIL basic_en_count: got %0d expected 8", n_en);
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d expected 1", n_done);
    end
    checks++;
    if ({busy1, st1, q1} !== {1'b0, ST_IDLE, 4'd2}) begin
      errors++;
      $display("FAIL basic_end: busy=%b state=%0d q=%0d expected busy=0 state=0 q=2", busy1, st1, q1);
    end
  endtask

  task automatic test_reject();
    int n_err, bad;
    pulse_reset();
    @(negedge clk);
    lo = 4'd5; hi = 4'd5; sweeps = 4'd1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if ({err1, en1, busy1} !== 3'b100) begin
      errors++;
      $display("FAIL reject_err: err/en/busy=%b expected 100", {err1, en1, busy1});
    end
    n_err = 0; bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (err1) n_err++;
      if (en1 || busy1) bad++;
    end
    checks++;
    if (n_err != 0) begin
      errors++;
      $display("FAIL reject_err_width: extra err cycles %0d expected 0", n_err);
    end
    checks++;
    if (bad != 0 || q1 !== 4'd0) begin
      errors++;
      $display("FAIL reject_idle: en/busy cycles=%0d q=%0d expected 0 and 0", bad, q1);
    end
  endtask

  task automatic test_stop();
    bit found;
    int n_done;
    pulse_reset();
    start1_pulse(4'd1, 4'd9, 4'd0);
    wait_up_at(4'd4, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stop_reach: q never reached 4 in UP (q=%0d)", q1);
    end
    checks++;
    if (en1 !== 1'b1) begin
      errors++;
      $display("FAIL stop_pre_en: got %b expected 1", en1);
    end
    stop = 1'b1;
    #1;
    checks++;
    if ({en1, busy1} !== 2'b01) begin
      errors++;
      $display("FAIL stop_same_cycle: en/busy=%b expected 01", {en1, busy1});
    end
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if ({busy1, st1, q1} !== {1'b0, ST_IDLE, 4'd4}) begin
      errors++;
      $display("FAIL stop_next: busy=%b state=%0d q=%0d expected 0 0 4", busy1, st1, q1);
    end
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done1 || en1) n_done++;
      @(negedge clk);
    end
    checks++;
    if (n_done != 0 || q1 !== 4'd4) begin
      errors++;
      $display("FAIL stop_quiet: done/en cycles=%0d q=%0d expected 0 and 4", n_done, q1);
    end
  endtask

  task automatic test_full_range();
    int n_en, n_done, n_wrap, n_top;
    bit tmo;
    pulse_reset();
    start1_pulse(4'd0, 4'd15, 4'd2);
    collect1(200, n_en, n_done, n_wrap, n_top, tmo);
    checks++;
    if (tmo) begin
      errors++;
      $display("FAIL full_timeout: no done within budget");
    end
    checks++;
    if (n_en != 60) begin
      errors++;
      $display("FAIL full_en_count: got %0d expected 60", n_en);
    end
    checks++;
    if (n_wrap != 0) begin
      errors++;
      $display("FAIL full_wrap: got %0d wrap steps expected 0", n_wrap);
    end
    checks++;
    if (n_top != 2) begin
      errors++;
      $display("FAIL full_top: reached 15 %0d times expected 2", n_top);
    end
    checks++;
    if (n_done != 1 || q1 !== 4'd0) begin
      errors++;
      $display("FAIL full_end: done=%0d q=%0d expected 1 and 0", n_done, q1);
    end
  endtask

  task automatic test_prescaler();
    int en_idx[$];
    int exp_idx[6];
    int n_done;
    exp_idx = '{3, 7, 11, 15, 19, 23};
    n_done = 0;
    pulse_reset();
    @(negedge clk);
    lo = 4'd0; hi = 4'd3; sweeps = 4'd1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (en4) en_idx.push_back(i);
      if (done4) n_done++;
      @(negedge clk);
    end
    checks++;
    if (en_idx.size() != 6) begin
      errors++;
      $display("FAIL presc_steps: got %0d expected 6", en_idx.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (en_idx[i] != exp_idx[i]) begin
          errors++;
          $display("FAIL presc_en_cycle[%0d]: got %0d expected %0d", i, en_idx[i], exp_idx[i]);
        end
      end
    end
    checks++;
    if (n_done != 1 || q4 !== 4'd0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL presc_end: done=%0d q=%0d busy=%b expected 1 0 0", n_done, q4, busy4);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    pulse_reset();
    start1_pulse(4'd1, 4'd9, 4'd0);
    wait_up_at(4'd3, found);
    checks++;
    if (!found || {en1, ud1, busy1} !== 3'b111) begin
      errors++;
      $display("FAIL rstmid_pre: found=%b en/ud/busy=%b expected 1 and 111", found, {en1, ud1, busy1});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({en1, ud1, busy1, done1, err1} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_async: outputs=%b expected 00000", {en1, ud1, busy1, done1, err1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({st1, busy1, en1} !== {ST_IDLE, 2'b00}) begin
      errors++;
      $display("FAIL rstmid_release: state=%0d busy=%b en=%b expected 0 0 0", st1, busy1, en1);
    end
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; stop = 1'b0;
    lo = 4'd0; hi = 4'd0; sweeps = 4'd0;
    test_reset();
    test_sweep_basic();
    test_reject();
    test_stop();
    test_full_range();
    test_prescaler();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
